// File: rtl/ika2151_timing_pkg.sv
// ---------------------------------------------------------------------------
// ika2151_timing_pkg
//   Shared constants and helpers for the slot/phase timing generator.
//   - OPM_* : default OPM timing (32 slots, SH and cycle-strobe positions)
//   - slot_dec_t : bundle of per-slot decode strobes kept in one register
//   - slot_width() : counter width for a given slot modulus
//   - in_window()  : modular window test used by the SH decodes
// ---------------------------------------------------------------------------
package ika2151_timing_pkg;

  localparam int OPM_SLOTS     = 32;
  localparam int OPM_PHI_DIV   = 2;
  localparam int OPM_SH1_START = 0;
  localparam int OPM_SH2_START = 16;
  localparam int OPM_SH_LEN    = 8;
  localparam int OPM_CYC_A0    = 12;
  localparam int OPM_CYC_A1    = 28;
  localparam int OPM_CYC_B0    = 5;
  localparam int OPM_CYC_B1    = 22;

  typedef struct packed {
    logic sh1;
    logic sh2;
    logic cyc_a;
    logic cyc_b_n;
    logic cyc_byte;
    logic frame;
  } slot_dec_t;

  function automatic int slot_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when slot lies in [start, start+len) taken modulo the slot count.
  // slot and start%modulus are both in 0..modulus-1, so one wrap-add suffices.
  function automatic logic in_window(input int slot, input int start,
                                     input int len, input int modulus);
    int d;
    d = slot - (start % modulus);
    if (d < 0) d = d + modulus;
    return (d < len);
  endfunction

endpackage

// File: rtl/mdl_timinggen_p_if.sv
// ---------------------------------------------------------------------------
// mdl_timinggen_p_if
//   Signal bundle between the timing generator and its consumers.
//   master : the generator (takes phiM enable / resync, drives all strobes)
//   slave  : a consumer or stimulus source (the reverse directions)
//   SLOT_W : width of o_SLOT, must equal slot_width(SLOTS) of the generator
// ---------------------------------------------------------------------------
interface mdl_timinggen_p_if #(
  parameter int SLOT_W = 5
);
  logic              i_phiM_PCEN_n;
  logic              i_SYNC_n;
  logic              o_MRST_n;
  logic              o_phi1;
  logic              o_phi1_PCEN_n;
  logic              o_phi1_NCEN_n;
  logic [SLOT_W-1:0] o_SLOT;
  logic              o_SH1;
  logic              o_SH2;
  logic              o_CYCLE_A;
  logic              o_CYCLE_B_n;
  logic              o_CYCLE_BYTE;
  logic              o_FRAME;

  modport master (
    input  i_phiM_PCEN_n, i_SYNC_n,
    output o_MRST_n, o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT,
           o_SH1, o_SH2, o_CYCLE_A, o_CYCLE_B_n, o_CYCLE_BYTE, o_FRAME
  );

  modport slave (
    output i_phiM_PCEN_n, i_SYNC_n,
    input  o_MRST_n, o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SLOT,
           o_SH1, o_SH2, o_CYCLE_A, o_CYCLE_B_n, o_CYCLE_BYTE, o_FRAME
  );
endinterface

// File: rtl/mdl_rstsync.sv
// ---------------------------------------------------------------------------
// mdl_rstsync
//   Two-flop reset synchroniser: asserts asynchronously with arst_n low,
//   releases on the second clk rising edge after arst_n goes high.
//   clk        in  clock
//   arst_n     in  asynchronous active-low reset
//   rst_sync_n out synchronised active-low reset
// ---------------------------------------------------------------------------
module mdl_rstsync (
  input  logic clk,
  input  logic arst_n,
  output logic rst_sync_n
);
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_reg[1];
endmodule

// File: rtl/mdl_timinggen_p.sv
// ---------------------------------------------------------------------------
// mdl_timinggen_p
//   Parametrised slot/phase timing generator. Divides the phiM tick enable
//   down to phi1 (with one-cycle rise/fall enables), runs a slot counter of
//   SLOTS positions advancing on each phi1 rise, and produces registered
//   SH1/SH2, cycle and frame strobes that always match the current slot.
//   A resync input reloads slot 0 at a phi1 rise for multi-chip alignment.
// Ports
//   i_EMUCLK  in  master clock, all flops on the rising edge
//   i_IC_n    in  asynchronous active-low reset
//   bus       master modport of mdl_timinggen_p_if:
//               i_phiM_PCEN_n, i_SYNC_n in; phi1, enables, slot, strobes out
// ---------------------------------------------------------------------------
module mdl_timinggen_p
  import ika2151_timing_pkg::*;
#(
  parameter int SLOTS     = OPM_SLOTS,
  parameter int PHI_DIV   = OPM_PHI_DIV,
  parameter int SH1_START = OPM_SH1_START,
  parameter int SH2_START = OPM_SH2_START,
  parameter int SH_LEN    = OPM_SH_LEN,
  parameter int CYC_A0    = OPM_CYC_A0,
  parameter int CYC_A1    = OPM_CYC_A1,
  parameter int CYC_B0    = OPM_CYC_B0,
  parameter int CYC_B1    = OPM_CYC_B1
) (
  input  logic              i_EMUCLK,
  input  logic              i_IC_n,
  mdl_timinggen_p_if.master bus
);

  localparam int W  = slot_width(SLOTS);
  localparam int PW = (PHI_DIV > 1) ? $clog2(PHI_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PHI_DIV - 1);
  localparam logic [W-1:0]  SLOT_LAST  = W'(SLOTS - 1);

  // ---- parameter sanity --------------------------------------------------
  if (SLOTS < 16 || SLOTS > 64) begin : g_chk_slots
    $error("mdl_timinggen_p: SLOTS=%0d out of range 16..64", SLOTS);
  end
  if (PHI_DIV < 1) begin : g_chk_div
    $error("mdl_timinggen_p: PHI_DIV=%0d must be >= 1", PHI_DIV);
  end
  if (SH_LEN == 0 || SH_LEN >= SLOTS) begin : g_chk_shlen
    $error("mdl_timinggen_p: SH_LEN=%0d must be 1..SLOTS-1", SH_LEN);
  end
  if (CYC_A0 >= SLOTS || CYC_A1 >= SLOTS || CYC_B0 >= SLOTS || CYC_B1 >= SLOTS) begin : g_chk_cyc
    $error("mdl_timinggen_p: a CYC_* position is >= SLOTS=%0d", SLOTS);
  end

  // ---- slot decode -------------------------------------------------------
  function automatic slot_dec_t decode(input logic [W-1:0] s);
    slot_dec_t d;
    int        si;
    si         = int'(s);
    d.sh1      = in_window(si, SH1_START, SH_LEN, SLOTS);
    d.sh2      = in_window(si, SH2_START, SH_LEN, SLOTS);
    d.cyc_a    = (si == CYC_A0) || (si == CYC_A1);
    d.cyc_b_n  = !((si == CYC_B0) || (si == CYC_B1));
    d.cyc_byte = (s[2:0] == 3'd7);
    d.frame    = (si == SLOTS - 1);
    return d;
  endfunction

  // Reset value of the decode register is whatever slot 0 decodes to, so
  // the strobes are consistent with o_SLOT even while held in reset.
  localparam slot_dec_t DEC_RST = decode(W'(0));

  // ---- reset synchroniser ------------------------------------------------
  logic rst_sync_n;

  mdl_rstsync u_rstsync (
    .clk        (i_EMUCLK),
    .arst_n     (i_IC_n),
    .rst_sync_n (rst_sync_n)
  );

  // ---- state -------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic          phi1_reg;
  logic          mrst_n_reg;
  logic [W-1:0]  slot_reg;
  slot_dec_t     dec_reg;

  logic          tick;
  logic          presc_wrap;
  logic          pcen;
  logic          ncen;
  logic [W-1:0]  slot_next;

  always_comb begin
    tick       = rst_sync_n & ~bus.i_phiM_PCEN_n;
    presc_wrap = tick && (presc_reg == PRESC_LAST);
    pcen       = presc_wrap & ~phi1_reg;
    ncen       = presc_wrap &  phi1_reg;

    // Until the first phi1 rise after release has set mrst_n_reg the counter
    // is pinned at 0; counting starts on the rise after that.
    slot_next = '0;
    if (mrst_n_reg && bus.i_SYNC_n && (slot_reg != SLOT_LAST)) begin
      slot_next = slot_reg + W'(1);
    end
  end

  // Prescaler and phi1: frozen whenever there is no phiM tick.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      presc_reg <= '0;
      phi1_reg  <= 1'b0;
    end else if (tick) begin
      if (presc_wrap) begin
        presc_reg <= '0;
        phi1_reg  <= ~phi1_reg;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  // Slot counter, master reset and decode strobes all update on phi1 rise.
  // The decode is taken from the value being loaded, not from slot_reg, so
  // the registered strobes and o_SLOT change on the same edge.
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      mrst_n_reg <= 1'b0;
      slot_reg   <= '0;
      dec_reg    <= DEC_RST;
    end else if (pcen) begin
      mrst_n_reg <= 1'b1;
      slot_reg   <= slot_next;
      dec_reg    <= decode(slot_next);
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign bus.o_MRST_n      = mrst_n_reg;
  assign bus.o_phi1        = phi1_reg;
  assign bus.o_phi1_PCEN_n = ~pcen;
  assign bus.o_phi1_NCEN_n = ~ncen;
  assign bus.o_SLOT        = slot_reg;
  assign bus.o_SH1         = dec_reg.sh1;
  assign bus.o_SH2         = dec_reg.sh2;
  assign bus.o_CYCLE_A     = dec_reg.cyc_a;
  assign bus.o_CYCLE_B_n   = dec_reg.cyc_b_n;
  assign bus.o_CYCLE_BYTE  = dec_reg.cyc_byte;
  assign bus.o_FRAME       = dec_reg.frame;

endmodule

// File: tb/tb_mdl_timinggen_p.sv
// ---------------------------------------------------------------------------
// tb_mdl_timinggen_p
//   Directed bench for mdl_timinggen_p. dut1 uses the default OPM timing,
//   dut2 uses SLOTS=24 / SH2_START=20 / CYC_A1=18 and runs in lockstep with
//   dut1 (shared clock, reset and phiM enable).
//   Inputs change at posedge+1 (phiM) or at negedge right after sampling
//   (reset, resync); outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_mdl_timinggen_p;

  logic clk = 1'b0;
  logic ic_n;
  bit   gate3 = 1'b0;
  int   gcnt;
  int   n_checks = 0;
  int   n_errors = 0;

  mdl_timinggen_p_if #(.SLOT_W(5)) bus1 ();
  mdl_timinggen_p_if #(.SLOT_W(5)) bus2 ();

  mdl_timinggen_p dut1 (
    .i_EMUCLK (clk),
    .i_IC_n   (ic_n),
    .bus      (bus1.master)
  );

  mdl_timinggen_p #(
    .SLOTS     (24),
    .SH2_START (20),
    .CYC_A1    (18)
  ) dut2 (
    .i_EMUCLK (clk),
    .i_IC_n   (ic_n),
    .bus      (bus2.master)
  );

  always #5 clk = ~clk;

  // phiM enable: every cycle, or one cycle in three when gate3 is set.
  initial begin
    gcnt = 0;
    bus1.i_phiM_PCEN_n = 1'b0;
    bus2.i_phiM_PCEN_n = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gate3) gcnt = (gcnt == 2) ? 0 : gcnt + 1;
      else       gcnt = 0;
      bus1.i_phiM_PCEN_n = (gcnt != 0);
      bus2.i_phiM_PCEN_n = (gcnt != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rst1(input string tag);
    chk({tag, "_mrst"},  32'(bus1.o_MRST_n),      32'd0);
    chk({tag, "_phi1"},  32'(bus1.o_phi1),        32'd0);
    chk({tag, "_pcen"},  32'(bus1.o_phi1_PCEN_n), 32'd1);
    chk({tag, "_ncen"},  32'(bus1.o_phi1_NCEN_n), 32'd1);
    chk({tag, "_slot"},  32'(bus1.o_SLOT),        32'd0);
    chk({tag, "_sh1"},   32'(bus1.o_SH1),         32'd1);
    chk({tag, "_sh2"},   32'(bus1.o_SH2),         32'd0);
    chk({tag, "_cyca"},  32'(bus1.o_CYCLE_A),     32'd0);
    chk({tag, "_cycb"},  32'(bus1.o_CYCLE_B_n),   32'd1);
    chk({tag, "_byte"},  32'(bus1.o_CYCLE_BYTE),  32'd0);
    chk({tag, "_frame"}, 32'(bus1.o_FRAME),       32'd0);
  endtask

  // Advance to the negedge just after the next phi1 rise of dut1.
  task automatic wait_rise(input string tag);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      if (bus1.o_phi1_PCEN_n === 1'b0) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (ok) @(negedge clk);
    chk({tag, "_rise_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_slot(input int target);
    int n;
    n = 0;
    while (int'(bus1.o_SLOT) != target && n < 80) begin
      wait_rise("seek");
      n++;
    end
    chk("seek_slot", 32'(bus1.o_SLOT), 32'(target));
  endtask

  // Cycles between two successive PCEN lows; also counts NCEN lows between.
  // Returns at the negedge where the second PCEN low is seen.
  task automatic measure(input int budget, output int period, output int ncen_lows);
    int n;
    period    = -1;
    ncen_lows = 0;
    n = 0;
    while (bus1.o_phi1_PCEN_n !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (period < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (bus1.o_phi1_NCEN_n === 1'b0) ncen_lows++;
      if (bus1.o_phi1_PCEN_n === 1'b0) period = n;
    end
  endtask

  initial begin
    int s, s2, frames1, frames2, per, ncl, n;

    // ---------------- reset state ----------------
    ic_n = 1'b0;
    bus1.i_SYNC_n = 1'b1;
    bus2.i_SYNC_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst1("rst");
    chk("rst_dut2_sh2", 32'(bus2.o_SH2), 32'd1);   // slot 0 is inside 20..3
    chk("rst_dut2_sh1", 32'(bus2.o_SH1), 32'd1);

    // ---------------- release (test 2) ----------------
    ic_n = 1'b1;
    @(negedge clk);
    chk("rel1_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd1);
    chk("rel1_mrst", 32'(bus1.o_MRST_n), 32'd0);
    @(negedge clk);
    chk("rel2_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd1);
    chk("rel2_phi1", 32'(bus1.o_phi1), 32'd0);
    @(negedge clk);
    chk("rel3_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd0);
    chk("rel3_mrst", 32'(bus1.o_MRST_n), 32'd0);
    @(negedge clk);
    chk("rel4_phi1", 32'(bus1.o_phi1), 32'd1);
    chk("rel4_mrst", 32'(bus1.o_MRST_n), 32'd1);
    chk("rel4_slot", 32'(bus1.o_SLOT), 32'd0);
    chk("rel4_slot2", 32'(bus2.o_SLOT), 32'd0);
    @(negedge clk);
    chk("rel5_ncen", 32'(bus1.o_phi1_NCEN_n), 32'd0);
    chk("rel5_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd1);
    @(negedge clk);
    chk("rel6_phi1", 32'(bus1.o_phi1), 32'd0);
    chk("rel6_ncen", 32'(bus1.o_phi1_NCEN_n), 32'd1);
    @(negedge clk);
    chk("rel7_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd0);
    chk("rel7_slot", 32'(bus1.o_SLOT), 32'd0);
    @(negedge clk);
    chk("rel8_phi1", 32'(bus1.o_phi1), 32'd1);
    chk("rel8_slot", 32'(bus1.o_SLOT), 32'd1);
    chk("rel8_slot2", 32'(bus2.o_SLOT), 32'd1);

    // ---------------- slot walk + decodes (tests 1, 3, 4) ----------------
    frames1 = 0;
    frames2 = 0;
    for (int k = 2; k < 34; k++) begin
      wait_rise("walk");
      s  = k % 32;
      s2 = k % 24;
      chk("walk_slot",  32'(bus1.o_SLOT),       32'(s));
      chk("walk_sh1",   32'(bus1.o_SH1),        32'(s < 8));
      chk("walk_sh2",   32'(bus1.o_SH2),        32'(s >= 16 && s < 24));
      chk("walk_cyca",  32'(bus1.o_CYCLE_A),    32'(s == 12 || s == 28));
      chk("walk_cycb",  32'(bus1.o_CYCLE_B_n),  32'(!(s == 5 || s == 22)));
      chk("walk_byte",  32'(bus1.o_CYCLE_BYTE), 32'(s == 7 || s == 15 || s == 23 || s == 31));
      chk("walk_frame", 32'(bus1.o_FRAME),      32'(s == 31));
      chk("walk2_slot", 32'(bus2.o_SLOT),       32'(s2));
      chk("walk2_sh2",  32'(bus2.o_SH2),        32'(s2 >= 20 || s2 < 4));
      chk("walk2_frame",32'(bus2.o_FRAME),      32'(s2 == 23));
      if (bus1.o_FRAME === 1'b1) frames1++;
      if (bus2.o_FRAME === 1'b1) frames2++;
    end
    chk("frames_per_32", 32'(frames1), 32'd1);
    chk("frames2_seen",  32'(frames2), 32'd1);

    measure(40, per, ncl);
    chk("phi1_period", 32'(per), 32'd4);
    chk("ncen_per_period", 32'(ncl), 32'd1);

    // ---------------- resync at slot 13 (test 5) ----------------
    wait_slot(13);
    chk("sync13_frame", 32'(bus1.o_FRAME), 32'd0);
    bus1.i_SYNC_n = 1'b0;
    measure(40, per, ncl);          // spans the resync rise
    chk("sync_period", 32'(per), 32'd4);
    chk("sync_slot0", 32'(bus1.o_SLOT), 32'd0);
    chk("sync_frame", 32'(bus1.o_FRAME), 32'd0);
    chk("sync_mrst",  32'(bus1.o_MRST_n), 32'd1);
    bus1.i_SYNC_n = 1'b1;
    wait_rise("sync_after");
    chk("sync_slot1", 32'(bus1.o_SLOT), 32'd1);

    // resync at the last slot equals a wrap; held low pins at 0
    wait_slot(31);
    chk("s31_frame", 32'(bus1.o_FRAME), 32'd1);
    bus1.i_SYNC_n = 1'b0;
    wait_rise("wrapsync");
    chk("wrapsync_slot", 32'(bus1.o_SLOT), 32'd0);
    chk("wrapsync_sh1",  32'(bus1.o_SH1),  32'd1);
    wait_rise("hold");
    chk("hold_slot", 32'(bus1.o_SLOT), 32'd0);
    bus1.i_SYNC_n = 1'b1;
    wait_rise("hold_rel");
    chk("hold_rel_slot", 32'(bus1.o_SLOT), 32'd1);

    // ---------------- mid-frame reset + gated phiM (test 6) ----------------
    wait_slot(17);
    chk("pre_ic_sh2", 32'(bus1.o_SH2), 32'd1);
    ic_n = 1'b0;
    #1;
    chk_rst1("ic_mid");
    gate3 = 1'b1;
    @(negedge clk);
    chk_rst1("ic_held");
    ic_n = 1'b1;
    n = 0;
    while (bus1.o_phi1_PCEN_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus1.o_phi1_PCEN_n !== 1'b0)
        chk("rec_mrst_low", 32'(bus1.o_MRST_n), 32'd0);
    end
    chk("rec_first_pcen", 32'(bus1.o_phi1_PCEN_n), 32'd0);
    chk("rec_pcen_mrst",  32'(bus1.o_MRST_n), 32'd0);
    @(negedge clk);
    chk("rec_rise_mrst", 32'(bus1.o_MRST_n), 32'd1);
    chk("rec_rise_slot", 32'(bus1.o_SLOT), 32'd0);
    chk("rec_rise_phi1", 32'(bus1.o_phi1), 32'd1);
    wait_rise("rec2");
    chk("rec2_slot", 32'(bus1.o_SLOT), 32'd1);
    measure(60, per, ncl);
    chk("gated_period", 32'(per), 32'd12);
    chk("gated_ncen",   32'(ncl), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
